amx_cmd_scheduler: RTL and testbench

Command scheduler in front of amx_core1's 5-bit command input. Two requesters each push 5-bit commands into a private FIFO. The scheduler arbitrates round-robin and issues at most one command per cycle to the core, with NOP (5'h00) on idle cycles. After long-latency opcodes it inserts a programmable number of NOP cycles before the next issue.

---
 rtl/amx_cmd_scheduler_if.sv | 31 +++
 rtl/amx_cmd_scheduler.sv | 135 +++++++++++++
 tb/tb_amx_cmd_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/amx_cmd_scheduler_if.sv
// Requester, hold and core-side signals of the command scheduler.
interface amx_cmd_scheduler_if #(
   parameter int unsigned CW = 5
);
   logic          req0_valid;
   logic [CW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [CW-1:0] req1_data;
   logic          req1_ready;
   logic          hold;
   logic [CW-1:0] core_cmd;
   logic          core_cmd_valid;
   logic          core_cmd_src;
   logic          busy;
   logic [7:0]    issue_count;

   // Requester/controller side
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, hold,
      input  req0_ready, req1_ready, core_cmd, core_cmd_valid, core_cmd_src,
             busy, issue_count
   );

   // Scheduler side
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, hold,
      output req0_ready, req1_ready, core_cmd, core_cmd_valid, core_cmd_src,
             busy, issue_count
   );
endinterface

// File: rtl/amx_cmd_scheduler.sv
// Two-requester round-robin command scheduler for amx_core1, with a
// programmable NOP gap after long-latency opcodes (top two bits = 2'b11).
module amx_cmd_scheduler #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LONG_WAIT = 3,
   parameter int unsigned CW        = 5
) (
   input logic                 clk,
   input logic                 rst_n,
   amx_cmd_scheduler_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned WW = 4;

   logic [CW-1:0] mem     [2][DEPTH];
   logic [PW-1:0] wr_ptr  [2];
   logic [PW-1:0] rd_ptr  [2];
   logic [CW-1:0] in_data [2];
   logic [CW-1:0] head    [2];
   logic [1:0]    in_valid;
   logic [1:0]    empty;
   logic [1:0]    full;
   logic [1:0]    push;
   logic [1:0]    pop;

   logic          issue;
   logic          grant;
   logic [CW-1:0] grant_cmd;
   logic          long_op;
   logic          rr_last;
   logic [WW-1:0] wait_cnt;

   logic [CW-1:0] cmd_q;
   logic          vld_q;
   logic          src_q;
   logic [7:0]    cnt_q;

   // FIFO status, push qualification and head read (extra pointer bit tells full from empty)
   always_comb begin
      in_valid   = {bus.req1_valid, bus.req0_valid};
      in_data    = '{default: '0};
      head       = '{default: '0};
      empty      = '0;
      full       = '0;
      push       = '0;
      in_data[0] = bus.req0_data;
      in_data[1] = bus.req1_data;
      for (int i = 0; i < 2; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
         push[i]  = in_valid[i] & ~full[i];
         head[i]  = mem[i][rd_ptr[i][AW-1:0]];
      end
   end

   // Eligibility and round-robin grant; rr_last names the last requester served
   always_comb begin
      issue     = 1'b0;
      grant     = 1'b0;
      pop       = '0;
      grant_cmd = '0;
      long_op   = 1'b0;
      issue     = ~bus.hold && (wait_cnt == '0) && ~&empty;
      grant     = (~empty[0] && ~empty[1]) ? ~rr_last : empty[0];
      grant_cmd = head[grant];
      long_op   = (grant_cmd[CW-1 -: 2] == 2'b11);
      if (issue) begin
         pop = grant ? 2'b10 : 2'b01;
      end
   end

   // FIFO storage; contents need no reset because pointers gate every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i][AW-1:0]] <= in_data[i];
         end
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
         end
      end
   end

   // Core-side output register, issue counter, arbitration history and NOP-gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q    <= '0;
         vld_q    <= 1'b0;
         src_q    <= 1'b0;
         cnt_q    <= '0;
         rr_last  <= 1'b1;
         wait_cnt <= '0;
      end else begin
         if (issue) begin
            cmd_q   <= grant_cmd;
            vld_q   <= 1'b1;
            src_q   <= grant;
            cnt_q   <= cnt_q + 8'd1;
            rr_last <= grant;
         end else begin
            cmd_q   <= '0;
            vld_q   <= 1'b0;
         end
         if (issue && long_op) begin
            wait_cnt <= WW'(LONG_WAIT);
         end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
         end
      end
   end

   assign bus.req0_ready     = ~full[0];
   assign bus.req1_ready     = ~full[1];
   assign bus.busy           = ~&empty | (wait_cnt != '0);
   assign bus.core_cmd       = cmd_q;
   assign bus.core_cmd_valid = vld_q;
   assign bus.core_cmd_src   = src_q;
   assign bus.issue_count    = cnt_q;

endmodule

// File: tb/tb_amx_cmd_scheduler.sv
// Scoreboard bench for amx_cmd_scheduler: stimulus queues expected issues,
// a negedge monitor pops and compares every issued command.
module tb_amx_cmd_scheduler;

   localparam int unsigned CW = 5;
   localparam int unsigned LW = 3;

   typedef struct {
      logic [CW-1:0] cmd;
      logic          src;
      int            gap;   // required cycles since previous issue; 0 = don't care
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   amx_cmd_scheduler_if #(.CW(CW)) bus ();

   amx_cmd_scheduler #(
      .DEPTH     (4),
      .LONG_WAIT (LW),
      .CW        (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       sb[$];
   exp_t       mon_e;
   int         total    = 0;
   int         bad      = 0;
   int         cyc      = 0;
   int         last_cyc = 0;
   logic [7:0] model_cnt = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input logic [CW-1:0] cmd, input logic src, input int gap);
      exp_t e;
      e.cmd = cmd;
      e.src = src;
      e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sb.delete();
      model_cnt = 8'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every issued command must match the scoreboard head
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.core_cmd_valid === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_issue: got cmd %0h src %0d want no issue (t=%0t)",
                        bus.core_cmd, bus.core_cmd_src, $time);
            end else begin
               mon_e = sb.pop_front();
               chk("issue_cmd", 32'(bus.core_cmd), 32'(mon_e.cmd));
               chk("issue_src", 32'(bus.core_cmd_src), 32'(mon_e.src));
               if (mon_e.gap > 0) chk("issue_gap", 32'(cyc - last_cyc), 32'(mon_e.gap));
               last_cyc  = cyc;
               model_cnt = model_cnt + 8'd1;
               chk("issue_count", 32'(bus.issue_count), 32'(model_cnt));
            end
         end else begin
            chk("idle_cmd", 32'(bus.core_cmd), 32'd0);
         end
      end
   end

   initial begin
      int  tries;
      logic ok;
      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.hold       = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_cmd",    32'(bus.core_cmd), 32'd0);
      chk("rst_valid",  32'(bus.core_cmd_valid), 32'd0);
      chk("rst_src",    32'(bus.core_cmd_src), 32'd0);
      chk("rst_count",  32'(bus.issue_count), 32'd0);
      chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
      chk("rst_ready1", 32'(bus.req1_ready), 32'd1);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single push: visible one edge after the push edge, then idle
      bus.req0_valid = 1'b1;
      bus.req0_data  = 5'h05;
      exp_push(5'h05, 1'b0, 0);
      tick();
      bus.req0_valid = 1'b0;
      chk("lat_not_yet", 32'(bus.core_cmd_valid), 32'd0);
      tick();
      chk("lat_valid", 32'(bus.core_cmd_valid), 32'd1);
      chk("lat_cmd",   32'(bus.core_cmd), 32'h05);
      tick();
      chk("single_idle_valid", 32'(bus.core_cmd_valid), 32'd0);
      chk("single_idle_busy",  32'(bus.busy), 32'd0);

      // Command 5'h00 is a real command
      bus.req0_valid = 1'b1;
      bus.req0_data  = 5'h00;
      exp_push(5'h00, 1'b0, 0);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      chk("zero_cmd_valid", 32'(bus.core_cmd_valid), 32'd1);
      tick();
      chk("zero_cmd_count", 32'(bus.issue_count), 32'd2);

      // Round-robin interleave from a fresh reset (requester 0 first)
      do_reset();
      bus.hold       = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.req0_data = CW'(5'h01 + k);
         bus.req1_data = CW'(5'h11 + k);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      exp_push(5'h01, 1'b0, 0);
      exp_push(5'h11, 1'b1, 1);
      exp_push(5'h02, 1'b0, 1);
      exp_push(5'h12, 1'b1, 1);
      exp_push(5'h03, 1'b0, 1);
      exp_push(5'h13, 1'b1, 1);
      chk("hold_blocks", 32'(bus.core_cmd_valid), 32'd0);
      bus.hold = 1'b0;
      repeat (8) tick();
      chk("rr_count", 32'(bus.issue_count), 32'd6);

      // Long op inserts LW NOP cycles before the next issue
      bus.hold       = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 5'h19;
      tick();
      bus.req0_data  = 5'h02;
      tick();
      bus.req0_valid = 1'b0;
      exp_push(5'h19, 1'b0, 0);
      exp_push(5'h02, 1'b0, LW + 1);
      bus.hold = 1'b0;
      tick();
      chk("long_busy", 32'(bus.busy), 32'd1);
      repeat (7) tick();
      chk("long_done_busy", 32'(bus.busy), 32'd0);

      // Full FIFO refuses a fifth push while held
      bus.hold       = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.req1_data = CW'(5'h0A + k);
         chk("ready_before_push", 32'(bus.req1_ready), 32'd1);
         exp_push(CW'(5'h0A + k), 1'b1, (k == 0) ? 0 : 1);
         tick();
      end
      bus.req1_data = 5'h0E;
      chk("ready_full", 32'(bus.req1_ready), 32'd0);
      tick();
      tick();
      chk("ready_still_full", 32'(bus.req1_ready), 32'd0);
      bus.req1_valid = 1'b0;
      bus.hold       = 1'b0;
      tick();
      chk("ready_after_pop", 32'(bus.req1_ready), 32'd1);
      repeat (6) tick();

      // Reset during the post-long-op wait discards queued entries
      bus.hold       = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 5'h1F;
      tick();
      bus.req0_data  = 5'h03;
      tick();
      bus.req0_data  = 5'h04;
      tick();
      bus.req0_valid = 1'b0;
      exp_push(5'h1F, 1'b0, 0);
      bus.hold = 1'b0;
      tick();
      tick();
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      sb.delete();
      model_cnt = 8'd0;
      #1;
      chk("async_rst_valid", 32'(bus.core_cmd_valid), 32'd0);
      chk("async_rst_cmd",   32'(bus.core_cmd), 32'd0);
      chk("async_rst_busy",  32'(bus.busy), 32'd0);
      chk("async_rst_count", 32'(bus.issue_count), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("post_rst_count", 32'(bus.issue_count), 32'd0);
      chk("post_rst_busy",  32'(bus.busy), 32'd0);

      // 256 issues wrap the counter back to 0
      bus.req0_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.req0_data = CW'(i % 16);
         exp_push(CW'(i % 16), 1'b0, 0);
         tries = 0;
         ok    = 1'b0;
         while (!ok && tries < 50) begin
            ok = bus.req0_ready;
            tick();
            tries++;
         end
         if (!ok) begin
            total++;
            bad++;
            $display("FAIL wrap_push_timeout: got ready 0 want 1 at push %0d", i);
            break;
         end
      end
      bus.req0_valid = 1'b0;
      tries = 0;
      while (sb.size() != 0 && tries < 100) begin
         tick();
         tries++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      tick();
      chk("wrap_count", 32'(bus.issue_count), 32'd0);
      chk("wrap_busy",  32'(bus.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
